// File: rtl/branch_resolve_unit.sv
// Branch resolution stage: flag-based RV32I condition evaluation, registered
// outcome with mispredict/redirect, 2-bit-counter BHT and saturating stats.
module branch_resolve_unit #(
    parameter int XLEN    = 32,
    parameter int ADDR_W  = 32,
    parameter int BHT_IDX = 4,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] lookup_pc,
    output logic              lookup_taken,
    input  logic              in_valid,
    input  logic [2:0]        funct3,
    input  logic [XLEN-1:0]   rs1,
    input  logic [XLEN-1:0]   rs2,
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] target,
    input  logic              pred_taken,
    input  logic              flush,
    output logic              res_valid,
    output logic              res_taken,
    output logic              mispredict,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic              illegal,
    output logic [CNT_W-1:0]  branch_cnt,
    output logic [CNT_W-1:0]  mispred_cnt
);

    localparam int BHT_N = 1 << BHT_IDX;

    logic [XLEN:0]        diff;
    logic                 z, s, v, c;
    logic                 cond;
    logic                 legal;
    logic [1:0]           bht [BHT_N];
    logic [BHT_IDX-1:0]   res_idx;
    logic [1:0]           bht_cur;
    logic [1:0]           bht_next;
    logic                 update;
    logic                 unused_bits;

    // Only the index bits of lookup_pc and the top two bits of diff matter.
    assign unused_bits = ^{lookup_pc, diff[XLEN-2:0]};

    // Flags from rs1 - rs2, then branch condition selected by funct3.
    always_comb begin
        diff  = {1'b0, rs1} + {1'b0, ~rs2} + (XLEN+1)'(1);
        z     = (rs1 == rs2);
        s     = diff[XLEN-1];
        c     = diff[XLEN];
        v     = (rs1[XLEN-1] != rs2[XLEN-1]) & (s != rs1[XLEN-1]);
        cond  = 1'b0;
        legal = 1'b1;
        case (funct3)
            3'b000:  cond = z;
            3'b001:  cond = ~z;
            3'b100:  cond = s ^ v;
            3'b101:  cond = ~(s ^ v);
            3'b110:  cond = ~c;
            3'b111:  cond = c;
            default: legal = 1'b0;
        endcase
    end

    // Capture the EX branch outcome; result registers are valid for one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_valid   <= 1'b0;
            res_taken   <= 1'b0;
            mispredict  <= 1'b0;
            illegal     <= 1'b0;
            redirect_pc <= '0;
            res_idx     <= '0;
        end else if (in_valid && !flush) begin
            res_valid   <= 1'b1;
            res_taken   <= cond;
            mispredict  <= legal & (cond != pred_taken);
            illegal     <= ~legal;
            redirect_pc <= cond ? target : pc + ADDR_W'(4);
            res_idx     <= pc[BHT_IDX+1:2];
        end else begin
            res_valid   <= 1'b0;
            mispredict  <= 1'b0;
            illegal     <= 1'b0;
        end
    end

    // Saturating 2-bit counter step for the entry being trained.
    always_comb begin
        update  = res_valid & ~illegal;
        bht_cur = bht[res_idx];
        bht_next = bht_cur;
        if (res_taken) begin
            if (bht_cur != 2'b11) bht_next = bht_cur + 2'b01;
        end else begin
            if (bht_cur != 2'b00) bht_next = bht_cur - 2'b01;
        end
    end

    // BHT storage; lookup reads the pre-update value in a training cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < BHT_N; i++) bht[i] <= 2'b01;
        end else if (update) begin
            bht[res_idx] <= bht_next;
        end
    end

    assign lookup_taken = bht[lookup_pc[BHT_IDX+1:2]][1];

    // Saturating statistics over legal resolved branches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else if (update) begin
            if (branch_cnt != '1) branch_cnt <= branch_cnt + CNT_W'(1);
            if (mispredict && (mispred_cnt != '1)) mispred_cnt <= mispred_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: directed branches push expected
// outcomes, a negedge monitor pops and compares on res_valid.
module tb_branch_resolve_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] lookup_pc;
    logic        in_valid, flush, pred_taken;
    logic [2:0]  funct3;
    logic [31:0] rs1, rs2, pc, target;

    logic        lookup_taken, res_valid, res_taken, mispredict, illegal;
    logic [31:0] redirect_pc;
    logic [15:0] branch_cnt, mispred_cnt;

    logic        s_lookup_taken, s_res_valid, s_res_taken, s_mispredict, s_illegal;
    logic [31:0] s_redirect_pc;
    logic [1:0]  s_branch_cnt, s_mispred_cnt;

    branch_resolve_unit dut (
        .clk(clk), .rst(rst), .lookup_pc(lookup_pc), .lookup_taken(lookup_taken),
        .in_valid(in_valid), .funct3(funct3), .rs1(rs1), .rs2(rs2), .pc(pc),
        .target(target), .pred_taken(pred_taken), .flush(flush),
        .res_valid(res_valid), .res_taken(res_taken), .mispredict(mispredict),
        .redirect_pc(redirect_pc), .illegal(illegal),
        .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
    );

    branch_resolve_unit #(.CNT_W(2)) dut_small (
        .clk(clk), .rst(rst), .lookup_pc(lookup_pc), .lookup_taken(s_lookup_taken),
        .in_valid(in_valid), .funct3(funct3), .rs1(rs1), .rs2(rs2), .pc(pc),
        .target(target), .pred_taken(pred_taken), .flush(flush),
        .res_valid(s_res_valid), .res_taken(s_res_taken), .mispredict(s_mispredict),
        .redirect_pc(s_redirect_pc), .illegal(s_illegal),
        .branch_cnt(s_branch_cnt), .mispred_cnt(s_mispred_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        taken;
        logic        misp;
        logic [31:0] redir;
        logic        ill;
        int          due;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compare each presented result against the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (res_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_res_valid", 64'(res_valid), 64'd0);
                end else begin
                    e = sb.pop_front();
                    check("latency",     64'(cyc),         64'(e.due));
                    check("res_taken",   64'(res_taken),   64'(e.taken));
                    check("mispredict",  64'(mispredict),  64'(e.misp));
                    check("redirect_pc", 64'(redirect_pc), 64'(e.redir));
                    check("illegal",     64'(illegal),     64'(e.ill));
                end
            end else if (sb.size() > 0 && sb[0].due <= cyc) begin
                check("res_valid_missing", 64'(res_valid), 64'd1);
                void'(sb.pop_front());
            end
        end
    end

    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] p, input logic [31:0] t, input logic pr,
                         input logic exp_taken, input logic do_flush, input logic push);
        exp_t e;
        @(posedge clk); #1;
        in_valid = 1'b1; flush = do_flush; funct3 = f3;
        rs1 = a; rs2 = b; pc = p; target = t; pred_taken = pr;
        if (push) begin
            e.taken = exp_taken;
            e.ill   = (f3 == 3'b010) || (f3 == 3'b011);
            e.misp  = !e.ill && (exp_taken != pr);
            e.redir = exp_taken ? t : p + 32'd4;
            e.due   = cyc + 1;
            sb.push_back(e);
        end
    endtask

    task automatic idle();
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; funct3 = 3'b000;
        rs1 = '0; rs2 = '0; pc = '0; target = '0; pred_taken = 1'b0; lookup_pc = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        for (int i = 0; i < 16; i++) begin
            lookup_pc = 32'(i) << 2;
            #1 check("reset_lookup", 64'(lookup_taken), 64'd0);
        end
        check("reset_branch_cnt",  64'(branch_cnt),  64'd0);
        check("reset_mispred_cnt", 64'(mispred_cnt), 64'd0);
        check("reset_res_valid",   64'(res_valid),   64'd0);

        // Four taken branches at 0x40: 01->10->11->11, read-before-write
        lookup_pc = 32'h40;
        issue(3'b000, 32'd1, 32'd1, 32'h40, 32'h80, 1'b0, 1'b1, 1'b0, 1'b1);
        @(negedge clk) check("bht_b1", 64'(lookup_taken), 64'd0);
        issue(3'b000, 32'd1, 32'd1, 32'h40, 32'h80, 1'b0, 1'b1, 1'b0, 1'b1);
        @(negedge clk) check("bht_b2_rbw", 64'(lookup_taken), 64'd0);
        issue(3'b000, 32'd1, 32'd1, 32'h40, 32'h80, 1'b1, 1'b1, 1'b0, 1'b1);
        @(negedge clk) check("bht_b3", 64'(lookup_taken), 64'd1);
        issue(3'b000, 32'd1, 32'd1, 32'h40, 32'h80, 1'b1, 1'b1, 1'b0, 1'b1);
        @(negedge clk) check("bht_b4", 64'(lookup_taken), 64'd1);
        idle();
        @(negedge clk) check("bht_sat", 64'(lookup_taken), 64'd1);

        // BEQ equal, mispredicted
        issue(3'b000, 32'd5, 32'd5, 32'h100, 32'h140, 1'b0, 1'b1, 1'b0, 1'b1);
        // BLT / BLTU with a negative vs positive operand
        issue(3'b100, 32'h8000_0000, 32'd1, 32'h204, 32'h300, 1'b0, 1'b1, 1'b0, 1'b1);
        issue(3'b110, 32'h8000_0000, 32'd1, 32'h204, 32'h300, 1'b1, 1'b0, 1'b0, 1'b1);
        // Remaining conditions and PC wrap
        issue(3'b001, 32'd3, 32'd4, 32'h10, 32'h20, 1'b1, 1'b1, 1'b0, 1'b1);
        issue(3'b101, 32'hFFFF_FFFF, 32'd0, 32'h14, 32'h24, 1'b0, 1'b0, 1'b0, 1'b1);
        issue(3'b111, 32'hFFFF_FFFF, 32'd0, 32'h18, 32'h28, 1'b1, 1'b1, 1'b0, 1'b1);
        issue(3'b100, 32'd7, 32'd7, 32'h1C, 32'h2C, 1'b0, 1'b0, 1'b0, 1'b1);
        issue(3'b000, 32'd1, 32'd2, 32'hFFFF_FFFC, 32'h8, 1'b0, 1'b0, 1'b0, 1'b1);

        // Flushed branch produces nothing; illegal funct3 leaves BHT untouched
        issue(3'b000, 32'd2, 32'd2, 32'h300, 32'h400, 1'b0, 1'b1, 1'b1, 1'b0);
        issue(3'b001, 32'd9, 32'd9, 32'h40, 32'h80, 1'b1, 1'b0, 1'b0, 1'b1);
        issue(3'b010, 32'd9, 32'd9, 32'h40, 32'h80, 1'b1, 1'b0, 1'b0, 1'b1);
        idle(); idle();
        @(negedge clk) check("bht_illegal_hold", 64'(lookup_taken), 64'd1);
        issue(3'b001, 32'd9, 32'd9, 32'h40, 32'h80, 1'b1, 1'b0, 1'b0, 1'b1);
        issue(3'b011, 32'd9, 32'd9, 32'h40, 32'h80, 1'b1, 1'b0, 1'b0, 1'b1);
        idle(); idle();
        @(negedge clk) check("bht_decrement", 64'(lookup_taken), 64'd0);

        // Stats: 14 legal branches, 7 mispredicts; CNT_W=2 instance saturates
        check("branch_cnt",        64'(branch_cnt),    64'd14);
        check("mispred_cnt",       64'(mispred_cnt),   64'd7);
        check("small_branch_sat",  64'(s_branch_cnt),  64'd3);
        check("small_mispred_sat", 64'(s_mispred_cnt), 64'd3);

        // Reset with a result staged
        lookup_pc = 32'h10;
        #1 check("bht_pre_reset", 64'(lookup_taken), 64'd1);
        issue(3'b000, 32'd1, 32'd1, 32'h500, 32'h600, 1'b0, 1'b1, 1'b0, 1'b0);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("rst_res_valid",   64'(res_valid),   64'd0);
        check("rst_res_taken",   64'(res_taken),   64'd0);
        check("rst_redirect",    64'(redirect_pc), 64'd0);
        check("rst_branch_cnt",  64'(branch_cnt),  64'd0);
        check("rst_small_cnt",   64'(s_mispred_cnt), 64'd0);
        check("rst_lookup",      64'(lookup_taken), 64'd0);
        in_valid = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        repeat (3) @(negedge clk) check("post_rst_no_valid", 64'(res_valid), 64'd0);

        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
